// File: rtl/wb_mem_master.sv
// wb_mem_master: Wishbone initiator for single core load/store/tag requests.
// Converts one request at a time into a bus cycle on the tagged RAM port,
// rejects misaligned accesses without touching the bus, formats read data
// and gives up on a cycle after TIMEOUT_CYCLES strobe cycles without ack.
//
// state | meaning
// IDLE  | ready for a request; bus quiet, address/data/sel/we held
// BUS   | cyc/stb asserted, waiting for ack or timeout
// RESP  | one-cycle response pulse; bus quiet (turnaround gap)

module wb_mem_master #(
    parameter int WB_DATA_WIDTH     = 32,
    parameter int WB_ADDR_WIDTH     = 32,
    parameter int WB_SEL_WIDTH      = 4,
    parameter int GRANULE_TAG_WIDTH = 4,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    // core request / response
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] req_data_i,
    input  logic                     req_we_i,
    input  logic [1:0]               req_size_i,
    input  logic                     req_signed_i,
    output logic                     rsp_valid_o,
    output logic [WB_DATA_WIDTH-1:0] rsp_data_o,
    output logic                     rsp_err_o,
    // wishbone initiator port
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
    output logic                     wb_we_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    input  logic                     wb_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_TAG  = 2'b11;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [1:0]               r_size;
    logic                     r_signed;
    logic [WB_ADDR_WIDTH-1:0] r_wb_addr;
    logic [WB_DATA_WIDTH-1:0] r_wb_data;
    logic [WB_SEL_WIDTH-1:0]  r_wb_sel;
    logic                     r_wb_we;
    logic [WB_DATA_WIDTH-1:0] r_rsp_data;
    logic                     r_rsp_err;

    logic                     w_misaligned;
    logic [WB_SEL_WIDTH-1:0]  w_sel;
    logic [WB_DATA_WIDTH-1:0] w_rd_fmt;
    logic                     w_accept;

    assign w_accept = (r_state == ST_IDLE) && req_valid_i;

    // Alignment check and byte-select encoding for the incoming request
    always_comb begin
        w_misaligned = 1'b0;
        w_sel        = WB_SEL_WIDTH'(4'b0001);
        case (req_size_i)
            SZ_BYTE: w_sel = WB_SEL_WIDTH'(4'b0001);
            SZ_HALF: begin
                w_sel        = WB_SEL_WIDTH'(4'b0011);
                w_misaligned = req_addr_i[0];
            end
            SZ_WORD: begin
                w_sel        = WB_SEL_WIDTH'(4'b1111);
                w_misaligned = (req_addr_i[1:0] != 2'b00);
            end
            SZ_TAG:  w_sel = WB_SEL_WIDTH'(4'b0101);
            default: w_sel = WB_SEL_WIDTH'(4'b0001);
        endcase
    end

    // Read data formatting from the captured size/sign of the bus cycle
    always_comb begin
        w_rd_fmt = '0;
        case (r_size)
            SZ_BYTE: w_rd_fmt = {{(WB_DATA_WIDTH-8){r_signed & wb_data_i[7]}},
                                 wb_data_i[7:0]};
            SZ_HALF: w_rd_fmt = {{(WB_DATA_WIDTH-16){r_signed & wb_data_i[15]}},
                                 wb_data_i[15:0]};
            SZ_WORD: w_rd_fmt = wb_data_i;
            SZ_TAG:  w_rd_fmt = {{(WB_DATA_WIDTH-GRANULE_TAG_WIDTH){1'b0}},
                                 wb_data_i[GRANULE_TAG_WIDTH-1:0]};
            default: w_rd_fmt = '0;
        endcase
    end

    // Control FSM with strobe timeout counter
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_state <= w_misaligned ? ST_RESP : ST_BUS;
                    end
                end
                ST_BUS: begin
                    // ack wins over a coincident timeout
                    if (wb_ack_i || (r_cnt == CNT_LAST)) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Bus request registers; held after the cycle so the slave can finish
    // sub-word writes and tag checks against the same address
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_wb_sel  <= '0;
            r_wb_we   <= 1'b0;
            r_size    <= SZ_BYTE;
            r_signed  <= 1'b0;
        end else if (w_accept && !w_misaligned) begin
            r_wb_addr <= req_addr_i;
            r_wb_data <= req_data_i;
            r_wb_sel  <= w_sel;
            r_wb_we   <= req_we_i;
            r_size    <= req_size_i;
            r_signed  <= req_signed_i;
        end
    end

    // Response payload, captured on the cycle that decides the outcome
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_misaligned) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                ST_BUS: begin
                    if (wb_ack_i) begin
                        r_rsp_data <= r_wb_we ? '0 : w_rd_fmt;
                        r_rsp_err  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // cyc/stb decode straight from state so reset drops them asynchronously
    assign wb_cyc_o    = (r_state == ST_BUS);
    assign wb_stb_o    = (r_state == ST_BUS);
    assign req_ready_o = (r_state == ST_IDLE);
    assign rsp_valid_o = (r_state == ST_RESP);
    assign rsp_data_o  = rsp_valid_o ? r_rsp_data : '0;
    assign rsp_err_o   = rsp_valid_o & r_rsp_err;

    assign wb_addr_o = r_wb_addr;
    assign wb_data_o = r_wb_data;
    assign wb_sel_o  = r_wb_sel;
    assign wb_we_o   = r_wb_we;

endmodule

// File: tb/tb_wb_mem_master.sv
// tb_wb_mem_master: directed stimulus with a response scoreboard for
// wb_mem_master; the bench also plays the Wishbone slave.

module tb_wb_mem_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] wb_addr;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_ack;
    logic [31:0] wb_dat_i;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];

    wb_mem_master #(
        .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .WB_SEL_WIDTH(4),
        .GRANULE_TAG_WIDTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_we_i(req_we),
        .req_size_i(req_size), .req_signed_i(req_signed),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .wb_addr_o(wb_addr), .wb_data_o(wb_dat_o), .wb_sel_o(wb_sel),
        .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
        .wb_ack_i(wb_ack), .wb_data_i(wb_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_stb_low", {31'd0, wb_stb}, 32'd0);
            end
        end
    end

    // Turnaround monitor: at least two strobe-low cycles before any new strobe
    int  low_cnt = 100;
    logic prev_stb = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            low_cnt  = 100;
            prev_stb = 1'b0;
        end else begin
            if (wb_stb && !prev_stb)
                chk("stb_gap_ge2", {31'd0, (low_cnt >= 2)}, 32'd1);
            if (wb_stb) low_cnt = 0;
            else        low_cnt++;
            prev_stb = wb_stb;
        end
    end

    // One request: drive it, act as slave (ack after ack_wait strobe cycles,
    // -1 = never), check bus fields and response timing.
    task automatic do_req(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic [1:0] size, input logic sgn,
                          input int ack_wait, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input logic exp_err,
                          input logic [3:0] exp_sel);
        logic mis;
        int   guard;
        int   n;
        rsp_t e;
        mis = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
        req_addr = addr; req_data = wdata; req_we = we;
        req_size = size; req_signed = sgn; req_valid = 1'b1;
        e.data = exp_data; e.err = exp_err;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (mis) begin
            chk({name, "_no_stb"}, {31'd0, wb_stb}, 32'd0);
            chk({name, "_rsp_lat"}, {31'd0, rsp_valid}, 32'd1);
            @(negedge clk);
            chk({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
            chk({name, "_no_stb2"}, {31'd0, wb_stb}, 32'd0);
            return;
        end
        chk({name, "_stb"}, {31'd0, wb_stb}, 32'd1);
        chk({name, "_cyc"}, {31'd0, wb_cyc}, 32'd1);
        chk({name, "_sel"}, {28'd0, wb_sel}, {28'd0, exp_sel});
        chk({name, "_we"}, {31'd0, wb_we}, {31'd0, we});
        chk({name, "_addr"}, wb_addr, addr);
        if (we) chk({name, "_wdata"}, wb_dat_o, wdata);
        chk({name, "_ready_low"}, {31'd0, req_ready}, 32'd0);
        n = 0;
        while (wb_stb && n < 100) begin
            if (n == ack_wait) begin
                wb_ack = 1'b1;
                wb_dat_i = rdata;
            end
            @(negedge clk);
            wb_ack = 1'b0;
            wb_dat_i = 32'hFFFF_FFFF;
            n++;
        end
        chk({name, "_stb_cycles"}, n, (ack_wait >= 0) ? ack_wait + 1 : 16);
        chk({name, "_rsp_lat"}, {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk({name, "_rsp_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
        chk({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
        req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        wb_ack = 1'b0; wb_dat_i = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_stb", {30'd0, wb_stb, wb_cyc}, 32'd0);
        chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        chk("rst_addr", wb_addr, 32'd0);
        chk("rst_wdata", wb_dat_o, 32'd0);
        chk("rst_sel_we", {27'd0, wb_sel, wb_we}, 32'd0);
        chk("rst_rdata", rsp_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req("word_ld",   32'h0000_0040, 32'h0, 1'b0, 2'b10, 1'b0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'b1111);
        do_req("byte_ld_s", 32'h0000_0043, 32'h0, 1'b0, 2'b00, 1'b1, 0, 32'h0000_0080, 32'hFFFF_FF80, 1'b0, 4'b0001);
        do_req("byte_ld_u", 32'h0000_0043, 32'h0, 1'b0, 2'b00, 1'b0, 0, 32'h0000_0080, 32'h0000_0080, 1'b0, 4'b0001);
        do_req("byte_st",   32'h0000_0041, 32'h0000_00AB, 1'b1, 2'b00, 1'b0, 0, 32'h1234_5678, 32'h0, 1'b0, 4'b0001);
        chk("held_addr", wb_addr, 32'h0000_0041);
        chk("held_wdata", wb_dat_o, 32'h0000_00AB);
        chk("held_sel_we", {27'd0, wb_sel, wb_we}, {27'd0, 4'b0001, 1'b1});
        do_req("half_ld_u", 32'h0000_0042, 32'h0, 1'b0, 2'b01, 1'b0, 0, 32'h0000_8001, 32'h0000_8001, 1'b0, 4'b0011);
        do_req("half_ld_s", 32'h0000_0042, 32'h0, 1'b0, 2'b01, 1'b1, 2, 32'h0000_8001, 32'hFFFF_8001, 1'b0, 4'b0011);
        do_req("tag_wr",    32'h3000_0010, 32'h0000_0003, 1'b1, 2'b11, 1'b0, 0, 32'h0, 32'h0, 1'b0, 4'b0101);
        do_req("tag_rd",    32'h3000_0010, 32'h0, 1'b0, 2'b11, 1'b0, 0, 32'h0000_0003, 32'h0000_0003, 1'b0, 4'b0101);
        do_req("tag_rd_msk",32'h3000_0010, 32'h0, 1'b0, 2'b11, 1'b0, 0, 32'h0000_00F3, 32'h0000_0003, 1'b0, 4'b0101);
        do_req("half_mis",  32'h0000_0041, 32'h0, 1'b0, 2'b01, 1'b0, 0, 32'h0, 32'h0, 1'b1, 4'b0011);
        chk("mis_addr_held", wb_addr, 32'h3000_0010);
        do_req("word_mis",  32'h0000_0042, 32'h0, 1'b0, 2'b10, 1'b0, 0, 32'h0, 32'h0, 1'b1, 4'b1111);
        do_req("timeout",   32'h0000_0080, 32'h0, 1'b0, 2'b10, 1'b0, -1, 32'h0, 32'h0, 1'b1, 4'b1111);
        do_req("ack_at_last", 32'h0000_0084, 32'h0, 1'b0, 2'b10, 1'b0, 15, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 4'b1111);

        // ack while idle must be ignored
        wb_ack = 1'b1; wb_dat_i = 32'h5555_5555;
        @(negedge clk);
        wb_ack = 1'b0; wb_dat_i = 32'hFFFF_FFFF;
        chk("idle_ack_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("idle_ack_no_rsp2", {30'd0, rsp_valid, wb_stb}, 32'd0);

        // reset in the middle of a bus cycle
        req_addr = 32'h0000_0100; req_we = 1'b0; req_size = 2'b10; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_stb_before", {31'd0, wb_stb}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_cyc_drop", {30'd0, wb_cyc, wb_stb}, 32'd0);
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_after_ready", {31'd0, req_ready}, 32'd1);
            chk("rstmid_after_quiet", {30'd0, rsp_valid, wb_stb}, 32'd0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "global timeout");
    end

endmodule
